// File: rtl/sb_tx_packet_framer.sv
`default_nettype none
// sb_tx_packet_framer: queues LTSM sideband message fields and streams 64-bit
// UCIe sideband headers (CP/DP parity) plus an optional payload word.
module sb_tx_packet_framer #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [2:0]  SRCID      = 3'b010,
   parameter logic [2:0]  DSTID      = 3'b110,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_msg_valid,
   output logic             o_msg_ready,
   input  logic [7:0]       i_msg_code,
   input  logic [7:0]       i_msg_subcode,
   input  logic [15:0]      i_msg_info,
   input  logic             i_has_data,
   input  logic [63:0]      i_data,
   input  logic             i_parity_en,
   output logic [63:0]      o_word,
   output logic             o_word_valid,
   input  logic             i_word_ready,
   output logic             o_word_is_hdr,
   output logic             o_overflow,
   output logic [CNT_W-1:0] o_pkt_count
);

   localparam int unsigned AW         = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE    = 1;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;
   localparam logic [4:0]  OPC_DATA   = 5'b11011;
   localparam logic [4:0]  OPC_NODATA = 5'b10010;

   typedef struct packed {
      logic [7:0]  code;
      logic [7:0]  subcode;
      logic [15:0] info;
      logic        has_data;
      logic [63:0] data;
   } msg_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      DATA = 2'd2
   } state_t;

   msg_t        mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        full;
   logic        empty;
   logic        push;
   logic        pop;
   msg_t        head;

   state_t            state;
   state_t            state_nxt;
   logic [63:0]       word_nxt;
   logic              valid_nxt;
   logic              is_hdr_nxt;
   logic              cur_has_data;
   logic              cur_has_data_nxt;
   logic [63:0]       cur_data;
   logic [63:0]       cur_data_nxt;
   logic [CNT_W-1:0]  count_nxt;
   logic              load_next;

   // Wrap bit distinguishes full from empty when the index bits match.
   assign empty       = (wr_ptr == rd_ptr);
   assign full        = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign o_msg_ready = !full;
   assign push        = i_msg_valid && !full;
   assign head        = mem[rd_ptr[AW-1:0]];

   function automatic logic [63:0] build_hdr(input msg_t m, input logic par_en);
      logic [63:0] h;
      h        = '0;
      h[4:0]   = m.has_data ? OPC_DATA : OPC_NODATA;
      h[21:14] = m.code;
      h[31:29] = SRCID;
      h[39:32] = m.subcode;
      h[55:40] = m.info;
      h[58:56] = DSTID;
      h[62]    = par_en & (^h[61:0]);
      h[63]    = par_en & m.has_data & (^m.data);
      return h;
   endfunction

   always_ff @(posedge i_clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= '{code: i_msg_code, subcode: i_msg_subcode,
                                  info: i_msg_info, has_data: i_has_data,
                                  data: i_data};
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         o_overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (i_msg_valid && full) begin
            o_overflow <= 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt        = state;
      word_nxt         = o_word;
      valid_nxt        = o_word_valid;
      is_hdr_nxt       = o_word_is_hdr;
      cur_has_data_nxt = cur_has_data;
      cur_data_nxt     = cur_data;
      count_nxt        = o_pkt_count;
      pop              = 1'b0;
      load_next        = 1'b0;

      case (state)
         IDLE: begin
            load_next = 1'b1;
         end
         HDR: begin
            if (i_word_ready) begin
               if (cur_has_data) begin
                  word_nxt   = cur_data;
                  is_hdr_nxt = 1'b0;
                  state_nxt  = DATA;
               end else begin
                  count_nxt = o_pkt_count + CNT_ONE;
                  load_next = 1'b1;
               end
            end
         end
         DATA: begin
            if (i_word_ready) begin
               count_nxt = o_pkt_count + CNT_ONE;
               load_next = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Chaining straight into the next header keeps the stream bubble-free.
      if (load_next) begin
         if (!empty) begin
            pop              = 1'b1;
            word_nxt         = build_hdr(head, i_parity_en);
            valid_nxt        = 1'b1;
            is_hdr_nxt       = 1'b1;
            cur_has_data_nxt = head.has_data;
            cur_data_nxt     = head.data;
            state_nxt        = HDR;
         end else begin
            valid_nxt  = 1'b0;
            is_hdr_nxt = 1'b0;
            state_nxt  = IDLE;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state         <= IDLE;
         o_word        <= '0;
         o_word_valid  <= 1'b0;
         o_word_is_hdr <= 1'b0;
         cur_has_data  <= 1'b0;
         cur_data      <= '0;
         o_pkt_count   <= '0;
      end else begin
         state         <= state_nxt;
         o_word        <= word_nxt;
         o_word_valid  <= valid_nxt;
         o_word_is_hdr <= is_hdr_nxt;
         cur_has_data  <= cur_has_data_nxt;
         cur_data      <= cur_data_nxt;
         o_pkt_count   <= count_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sb_tx_packet_framer.sv
`default_nettype none
// tb_sb_tx_packet_framer: directed and randomized checks of the sideband
// framer against a word-stream reference model.
module tb_sb_tx_packet_framer;

   logic        clk = 1'b0;
   logic        rst;
   logic        msg_valid;
   logic [7:0]  msg_code;
   logic [7:0]  msg_subcode;
   logic [15:0] msg_info;
   logic        has_data;
   logic [63:0] data;
   logic        parity_en;
   logic        word_ready;

   logic        msg_ready, word_valid, word_is_hdr, overflow;
   logic [63:0] word;
   logic [15:0] pkt_count;
   logic        msg_ready_4, word_valid_4, word_is_hdr_4, overflow_4;
   logic [63:0] word_4;
   logic [3:0]  pkt_count_4;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [63:0] exp_q[$];
   logic        exp_hdr_q[$];
   logic        exp_last_q[$];

   always #5 clk = ~clk;

   sb_tx_packet_framer dut (
      .i_clk(clk), .i_rst(rst), .i_msg_valid(msg_valid), .o_msg_ready(msg_ready),
      .i_msg_code(msg_code), .i_msg_subcode(msg_subcode), .i_msg_info(msg_info),
      .i_has_data(has_data), .i_data(data), .i_parity_en(parity_en),
      .o_word(word), .o_word_valid(word_valid), .i_word_ready(word_ready),
      .o_word_is_hdr(word_is_hdr), .o_overflow(overflow), .o_pkt_count(pkt_count)
   );

   sb_tx_packet_framer #(.CNT_W(4)) dut4 (
      .i_clk(clk), .i_rst(rst), .i_msg_valid(msg_valid), .o_msg_ready(msg_ready_4),
      .i_msg_code(msg_code), .i_msg_subcode(msg_subcode), .i_msg_info(msg_info),
      .i_has_data(has_data), .i_data(data), .i_parity_en(parity_en),
      .o_word(word_4), .o_word_valid(word_valid_4), .i_word_ready(word_ready),
      .o_word_is_hdr(word_is_hdr_4), .o_overflow(overflow_4), .o_pkt_count(pkt_count_4)
   );

   // Reference header straight from the field map; CP covers bits 61:0.
   function automatic logic [63:0] model_hdr(input logic [7:0] code, input logic [7:0] sub,
                                             input logic [15:0] info, input logic hd,
                                             input logic [63:0] d, input logic pen);
      logic [61:0] body;
      body = {3'b000, 3'b110, info, sub, 3'b010, 7'd0, code, 9'd0,
              hd ? 5'b11011 : 5'b10010};
      return {pen & hd & (^d), pen & (^body), body};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      msg_valid  = 1'b0;
      word_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic drive_msg(input logic [7:0] c, input logic [7:0] s, input logic [15:0] inf,
                            input logic hd, input logic [63:0] d);
      msg_valid   = 1'b1;
      msg_code    = c;
      msg_subcode = s;
      msg_info    = inf;
      has_data    = hd;
      data        = d;
   endtask

   task automatic drive_random_msg(input logic hd);
      drive_msg(8'($urandom), 8'($urandom), 16'($urandom), hd, {$urandom, $urandom});
   endtask

   task automatic model_push();
      exp_q.push_back(model_hdr(msg_code, msg_subcode, msg_info, has_data, data, parity_en));
      exp_hdr_q.push_back(1'b1);
      exp_last_q.push_back(!has_data);
      if (has_data) begin
         exp_q.push_back(data);
         exp_hdr_q.push_back(1'b0);
         exp_last_q.push_back(1'b1);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; msg_valid = 1'b0; word_ready = 1'b0; parity_en = 1'b1;
      drive_msg(8'h00, 8'h00, 16'h0, 1'b0, 64'h0);
      msg_valid = 1'b0;
      step();
      step();
      rst = 1'b0;
      tests_run++;
      if (word !== 64'h0 || word_valid !== 1'b0 || word_is_hdr !== 1'b0 ||
          overflow !== 1'b0 || pkt_count !== 16'h0 || msg_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_state: word=%h valid=%b hdr=%b ovf=%b cnt=%0d rdy=%b, required all 0 and rdy=1",
                  word, word_valid, word_is_hdr, overflow, pkt_count, msg_ready);
      end
   endtask

   task automatic test_single_header();
      logic [63:0] exp;
      do_reset();
      parity_en = 1'b1;
      word_ready = 1'b1;
      drive_msg(8'h95, 8'h01, 16'h0000, 1'b0, 64'h0);
      exp = model_hdr(8'h95, 8'h01, 16'h0000, 1'b0, 64'h0, 1'b1);
      step();
      msg_valid = 1'b0;
      tests_run++;
      if (word_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_latency: valid=%b one edge after push, required 0", word_valid);
      end
      step();
      // hdr[61:0] of this message has an even number of ones, so CP is 0.
      tests_run++;
      if (word_valid !== 1'b1 || word_is_hdr !== 1'b1 || word !== exp ||
          word !== 64'h0600_0001_4025_4012) begin
         tests_failed++;
         $display("FAIL single_header: word=%h valid=%b hdr=%b, required %h valid=1 hdr=1",
                  word, word_valid, word_is_hdr, exp);
      end
      step();
      tests_run++;
      if (word_valid !== 1'b0 || pkt_count !== 16'd1) begin
         tests_failed++;
         $display("FAIL single_count: valid=%b cnt=%0d, required valid=0 cnt=1", word_valid, pkt_count);
      end
   endtask

   task automatic test_parity_disabled();
      logic [7:0]  codes [4] = '{8'h95, 8'h94, 8'h94, 8'hA5};
      logic        pens  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [63:0] lits  [4] = '{64'h0600_0001_4025_4012, 64'h4600_0001_4025_0012,
                                 64'h0600_0001_4025_0012, 64'h0600_0000_4029_401B};
      for (int i = 0; i < 4; i++) begin
         do_reset();
         parity_en  = pens[i];
         word_ready = 1'b0;
         drive_msg(codes[i], 8'h01 & {8{i != 3}}, 16'h0000, i == 3, 64'h1);
         step();
         msg_valid = 1'b0;
         step();
         tests_run++;
         if (word !== lits[i] || word !== model_hdr(codes[i], 8'h01 & {8{i != 3}}, 16'h0,
                                                    i == 3, 64'h1, pens[i])) begin
            tests_failed++;
            $display("FAIL parity_case%0d: word=%h, required %h", i, word, lits[i]);
         end
      end
      parity_en = 1'b1;
   endtask

   task automatic test_data_packet();
      logic [63:0] exp;
      do_reset();
      parity_en  = 1'b1;
      word_ready = 1'b0;
      drive_msg(8'hA5, 8'h00, 16'h0000, 1'b1, 64'h1);
      exp = model_hdr(8'hA5, 8'h00, 16'h0000, 1'b1, 64'h1, 1'b1);
      step();
      msg_valid = 1'b0;
      step();
      tests_run++;
      if (word[4:0] !== 5'h1B || word[63] !== 1'b1 || word !== exp || word_is_hdr !== 1'b1 ||
          pkt_count !== 16'd0) begin
         tests_failed++;
         $display("FAIL data_header: word=%h hdr=%b cnt=%0d, required %h hdr=1 cnt=0",
                  word, word_is_hdr, pkt_count, exp);
      end
      word_ready = 1'b1;
      step();
      word_ready = 1'b0;
      tests_run++;
      if (word !== 64'h1 || word_is_hdr !== 1'b0 || word_valid !== 1'b1 || pkt_count !== 16'd0) begin
         tests_failed++;
         $display("FAIL data_payload: word=%h hdr=%b valid=%b cnt=%0d, required 1 hdr=0 valid=1 cnt=0",
                  word, word_is_hdr, word_valid, pkt_count);
      end
      step();
      word_ready = 1'b1;
      step();
      tests_run++;
      if (pkt_count !== 16'd1 || word_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL data_count: cnt=%0d valid=%b, required cnt=1 valid=0", pkt_count, word_valid);
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] hdrs [5];
      do_reset();
      parity_en  = 1'b1;
      word_ready = 1'b0;
      // One message sits in the output register, four fill the queue.
      for (int i = 0; i < 5; i++) begin
         drive_random_msg(1'b0);
         hdrs[i] = model_hdr(msg_code, msg_subcode, msg_info, 1'b0, data, 1'b1);
         tests_run++;
         if (msg_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_ready_push%0d: rdy=%b, required 1", i, msg_ready);
         end
         step();
      end
      drive_random_msg(1'b0);
      tests_run++;
      if (msg_ready !== 1'b0 || overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_full: rdy=%b ovf=%b, required rdy=0 ovf=0", msg_ready, overflow);
      end
      step();
      msg_valid = 1'b0;
      tests_run++;
      if (overflow !== 1'b1) begin
         tests_failed++;
         $display("FAIL bp_overflow: ovf=%b, required 1", overflow);
      end
      for (int i = 0; i < 10; i++) begin
         tests_run++;
         if (word_valid !== 1'b1 || word !== hdrs[0] || msg_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_stall%0d: word=%h valid=%b rdy=%b, required %h valid=1 rdy=0",
                     i, word, word_valid, msg_ready, hdrs[0]);
         end
         step();
      end
      word_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tests_run++;
         if (word_valid !== 1'b1 || word_is_hdr !== 1'b1 || word !== hdrs[i]) begin
            tests_failed++;
            $display("FAIL bp_drain%0d: word=%h valid=%b hdr=%b, required %h valid=1 hdr=1",
                     i, word, word_valid, word_is_hdr, hdrs[i]);
         end
         step();
      end
      tests_run++;
      if (word_valid !== 1'b0 || pkt_count !== 16'd5 || overflow !== 1'b1) begin
         tests_failed++;
         $display("FAIL bp_end: valid=%b cnt=%0d ovf=%b, required valid=0 cnt=5 ovf=1",
                  word_valid, pkt_count, overflow);
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] hdrs [6];
      do_reset();
      parity_en  = 1'b1;
      word_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         if (c < 6) begin
            drive_random_msg(1'b0);
            hdrs[c] = model_hdr(msg_code, msg_subcode, msg_info, 1'b0, data, 1'b1);
         end else begin
            msg_valid = 1'b0;
         end
         if (c >= 2) begin
            tests_run++;
            if (word_valid !== 1'b1 || word !== hdrs[c-2]) begin
               tests_failed++;
               $display("FAIL b2b_word%0d: word=%h valid=%b, required %h valid=1",
                        c - 2, word, word_valid, hdrs[c-2]);
            end
         end
         step();
      end
      tests_run++;
      if (word_valid !== 1'b0 || pkt_count !== 16'd6) begin
         tests_failed++;
         $display("FAIL b2b_end: valid=%b cnt=%0d, required valid=0 cnt=6", word_valid, pkt_count);
      end
   endtask

   task automatic test_counter_wrap();
      int tries;
      do_reset();
      word_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         drive_random_msg(1'b0);
         tries = 0;
         while (msg_ready !== 1'b1 && tries < 20) begin
            step();
            tries++;
         end
         step();
      end
      msg_valid = 1'b0;
      tries = 0;
      while (word_valid !== 1'b0 && tries < 30) begin
         step();
         tries++;
      end
      tests_run++;
      if (pkt_count_4 !== 4'd1 || pkt_count !== 16'd17 || word_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL counter_wrap: cnt4=%0d cnt16=%0d valid=%b, required cnt4=1 cnt16=17 valid=0",
                  pkt_count_4, pkt_count, word_valid);
      end
   endtask

   task automatic test_reset_mid_packet();
      do_reset();
      parity_en  = 1'b1;
      word_ready = 1'b0;
      drive_random_msg(1'b1);
      step();
      drive_random_msg(1'b0);
      step();
      drive_random_msg(1'b1);
      word_ready = 1'b1;
      step();
      msg_valid  = 1'b0;
      word_ready = 1'b0;
      tests_run++;
      if (word_valid !== 1'b1 || word_is_hdr !== 1'b0) begin
         tests_failed++;
         $display("FAIL midrst_setup: valid=%b hdr=%b, required valid=1 hdr=0", word_valid, word_is_hdr);
      end
      step();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      tests_run++;
      if (word !== 64'h0 || word_valid !== 1'b0 || word_is_hdr !== 1'b0 || overflow !== 1'b0 ||
          pkt_count !== 16'h0 || msg_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL midrst_state: word=%h valid=%b hdr=%b ovf=%b cnt=%0d rdy=%b, required zeros rdy=1",
                  word, word_valid, word_is_hdr, overflow, pkt_count, msg_ready);
      end
      word_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         tests_run++;
         if (word_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_quiet%0d: valid=%b, required 0", i, word_valid);
         end
      end
   endtask

   task automatic test_random_stream(input int n_msgs, input int ready_pct);
      int          sent = 0;
      int          done_pkts = 0;
      int          cycles = 0;
      logic        prev_stall = 1'b0;
      logic [63:0] prev_word = '0;
      logic [63:0] e;
      logic        eh, el;
      do_reset();
      parity_en = 1'($urandom_range(0, 1));
      exp_q.delete();
      exp_hdr_q.delete();
      exp_last_q.delete();
      while ((sent < n_msgs || exp_q.size() != 0) && cycles < 3000) begin
         if (prev_stall) begin
            tests_run++;
            if (word_valid !== 1'b1 || word !== prev_word) begin
               tests_failed++;
               $display("FAIL rnd_stable: word=%h valid=%b, required %h valid=1", word, word_valid, prev_word);
            end
         end
         if (sent < n_msgs && $urandom_range(0, 99) < 70)
            drive_random_msg(1'($urandom_range(0, 1)));
         else
            msg_valid = 1'b0;
         word_ready = ($urandom_range(0, 99) < ready_pct);
         if (msg_valid && msg_ready) begin
            model_push();
            sent++;
         end
         if (word_valid && word_ready) begin
            tests_run++;
            if (exp_q.size() == 0) begin
               tests_failed++;
               $display("FAIL rnd_extra: word=%h emitted, required no word", word);
            end else begin
               e  = exp_q.pop_front();
               eh = exp_hdr_q.pop_front();
               el = exp_last_q.pop_front();
               if (el) done_pkts++;
               if (word !== e || word_is_hdr !== eh) begin
                  tests_failed++;
                  $display("FAIL rnd_word: word=%h hdr=%b, required %h hdr=%b", word, word_is_hdr, e, eh);
               end
            end
         end
         prev_stall = word_valid && !word_ready;
         prev_word  = word;
         step();
         cycles++;
      end
      msg_valid  = 1'b0;
      word_ready = 1'b1;
      tests_run++;
      if (cycles >= 3000) begin
         tests_failed++;
         $display("FAIL rnd_timeout: %0d words outstanding, required 0", exp_q.size());
      end
      tests_run++;
      if (word_valid !== 1'b0 || pkt_count !== 16'(done_pkts) ||
          pkt_count_4 !== done_pkts[3:0]) begin
         tests_failed++;
         $display("FAIL rnd_end: valid=%b cnt=%0d cnt4=%0d, required valid=0 cnt=%0d cnt4=%0d",
                  word_valid, pkt_count, pkt_count_4, done_pkts, done_pkts[3:0]);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_header();
      test_parity_disabled();
      test_data_packet();
      test_backpressure();
      test_back_to_back();
      test_counter_wrap();
      test_reset_mid_packet();
      test_random_stream(40, 70);
      test_random_stream(40, 30);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
